// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared types for the branch predictor update path: the queued update payload,
// the update controller state encoding and the PC-to-table-index helper.
// ----------------------------------------------------------------------------
package bp_pkg;

   localparam int unsigned BP_IDX_W  = 8;
   localparam int unsigned BP_PC_W   = 64;
   localparam int unsigned BP_STAT_W = 32;

   // One pending counter-table training update
   typedef struct packed {
      logic [BP_IDX_W-1:0] idx;
      logic                taken;
   } bp_upd_t;

   typedef enum logic {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } bp_upd_state_t;

   // Table index is pc[BP_IDX_W+1:2]; instructions are word aligned
   function automatic logic [BP_IDX_W-1:0] IDX_OF(input logic [BP_PC_W-1:0] pc);
      return BP_IDX_W'(pc >> 2);
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// ----------------------------------------------------------------------------
// bp_upd_fifo
// Small circular FIFO of pending predictor updates. No write-to-read bypass:
// a pushed entry becomes visible on o_head the cycle after the push.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_push, i_data  enqueue request and payload (ignored when full)
//   i_pop           dequeue request (ignored when empty)
//   i_flush         discard all contents (wins over push/pop)
//   o_head          oldest entry
//   o_count         occupancy, 0..DEPTH
//   o_full, o_empty occupancy flags derived from the registered count
// ----------------------------------------------------------------------------
module bp_upd_fifo
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  bp_upd_t                  i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output bp_upd_t                  o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   bp_upd_t         r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop  & ~o_empty;

   // Storage; pointer reset on flush makes stale data unreachable
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// ----------------------------------------------------------------------------
// bp_update_ctrl
// Owns the single write port of the branch predictor 2-bit counter table.
// After reset or clear_req it sweeps every entry to weakly-not-taken (fetch is
// stalled meanwhile), then buffers commit-stage branch resolutions in a FIFO
// and drains one per enabled cycle into the table.
// Optional feature macro: BP_UPD_STATS_EN adds saturating enqueue statistics.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   en                  pipeline enable; FIFO drains only while high
//   clear_req           pulse: flush queue, restart the sweep
//   commit_*            retiring instruction (valid, is_branch, pc, taken, mispred)
//   commit_ready        branch resolution can be accepted this cycle
//   upd_valid/init/idx/taken  table write strobe, init flag, entry, direction
//   fetch_stall         high while sweeping
//   stat_branches/stat_mispreds  [BP_UPD_STATS_EN] enqueued branch counts
// ----------------------------------------------------------------------------
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned BPB_ENTRY_WIDTH = BP_IDX_W,
   parameter int unsigned BPB_ENTRY_LINE  = 2 ** BP_IDX_W,
   parameter int unsigned UPD_QDEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        clear_req,
   input  logic                        commit_valid,
   input  logic                        commit_is_branch,
   input  logic [BP_PC_W-1:0]          commit_pc,
   input  logic                        commit_taken,
   input  logic                        commit_mispred,
   output logic                        commit_ready,
   output logic                        upd_valid,
   output logic                        upd_init,
   output logic [BPB_ENTRY_WIDTH-1:0]  upd_idx,
   output logic                        upd_taken,
   output logic                        fetch_stall
`ifdef BP_UPD_STATS_EN
   ,
   output logic [BP_STAT_W-1:0]        stat_branches,
   output logic [BP_STAT_W-1:0]        stat_mispreds
`endif
);

   localparam int unsigned QCW = $clog2(UPD_QDEPTH) + 1;
   localparam logic [BPB_ENTRY_WIDTH-1:0] LAST_IDX = BPB_ENTRY_WIDTH'(BPB_ENTRY_LINE - 1);

   bp_upd_state_t                r_state;
   bp_upd_state_t                w_state_nxt;
   logic [BPB_ENTRY_WIDTH-1:0]   r_sweep_idx;
   logic [BPB_ENTRY_WIDTH-1:0]   w_sweep_nxt;

   logic                         w_push;
   logic                         w_pop;
   bp_upd_t                      w_push_data;
   bp_upd_t                      w_head;
   logic [QCW-1:0]               w_count;
   logic                         w_full;
   logic                         w_empty;

   assign w_push_data.idx   = IDX_OF(commit_pc);
   assign w_push_data.taken = commit_taken;

   bp_upd_fifo #(
      .DEPTH   (UPD_QDEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (clear_req),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State and sweep counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= SWEEP;
         r_sweep_idx <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_idx <= w_sweep_nxt;
      end
   end

   // Next state, table write port and commit handshake
   always_comb begin
      w_state_nxt  = r_state;
      w_sweep_nxt  = r_sweep_idx;
      commit_ready = 1'b0;
      upd_valid    = 1'b0;
      upd_init     = 1'b0;
      upd_idx      = '0;
      upd_taken    = 1'b0;
      fetch_stall  = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;

      case (r_state)
         SWEEP: begin
            upd_valid   = 1'b1;
            upd_init    = 1'b1;
            upd_idx     = r_sweep_idx;
            fetch_stall = 1'b1;
            w_sweep_nxt = r_sweep_idx + BPB_ENTRY_WIDTH'(1);
            if (r_sweep_idx == LAST_IDX) begin
               w_state_nxt = RUN;
               w_sweep_nxt = '0;
            end
         end
         RUN: begin
            // Ready reflects the registered count, so a full queue stays
            // not-ready even in a cycle that pops
            commit_ready = ~w_full;
            upd_valid    = ~w_empty;
            upd_idx      = BPB_ENTRY_WIDTH'(w_head.idx);
            upd_taken    = w_head.taken;
            w_push       = commit_valid & commit_is_branch & ~w_full & ~clear_req;
            w_pop        = ~w_empty & en;
         end
         default: begin
            w_state_nxt = SWEEP;
            w_sweep_nxt = '0;
         end
      endcase

      if (clear_req) begin
         w_state_nxt = SWEEP;
         w_sweep_nxt = '0;
      end
   end

`ifdef BP_UPD_STATS_EN
   logic [BP_STAT_W-1:0] r_stat_br;
   logic [BP_STAT_W-1:0] r_stat_mp;

   // Saturating counts of accepted branch resolutions
   always_ff @(posedge clk) begin
      if (reset || clear_req) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (w_push) begin
         if (r_stat_br != '1) begin
            r_stat_br <= r_stat_br + BP_STAT_W'(1);
         end
         if (commit_mispred && (r_stat_mp != '1)) begin
            r_stat_mp <= r_stat_mp + BP_STAT_W'(1);
         end
      end
   end

   assign stat_branches = r_stat_br;
   assign stat_mispreds = r_stat_mp;

   logic w_unused_ok;
   assign w_unused_ok = ^w_count;
`else
   // Mispredict flag only feeds the optional statistics
   logic w_unused_ok;
   assign w_unused_ok = ^{w_count, commit_mispred};
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bp_update_ctrl
// Directed stimulus for bp_update_ctrl. Every table write the stimulus expects
// is queued; a negedge monitor pops and compares each write the DUT performs.
// ----------------------------------------------------------------------------
module tb_bp_update_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        clear_req;
   logic        commit_valid;
   logic        commit_is_branch;
   logic [63:0] commit_pc;
   logic        commit_taken;
   logic        commit_mispred;
   logic        commit_ready;
   logic        upd_valid;
   logic        upd_init;
   logic [7:0]  upd_idx;
   logic        upd_taken;
   logic        fetch_stall;
`ifdef BP_UPD_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispreds;
`endif

   always #5 clk = ~clk;

   bp_update_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .en               (en),
      .clear_req        (clear_req),
      .commit_valid     (commit_valid),
      .commit_is_branch (commit_is_branch),
      .commit_pc        (commit_pc),
      .commit_taken     (commit_taken),
      .commit_mispred   (commit_mispred),
      .commit_ready     (commit_ready),
      .upd_valid        (upd_valid),
      .upd_init         (upd_init),
      .upd_idx          (upd_idx),
      .upd_taken        (upd_taken),
      .fetch_stall      (fetch_stall)
`ifdef BP_UPD_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispreds    (stat_mispreds)
`endif
   );

   typedef struct {
      logic       init;
      logic [7:0] idx;
      logic       taken;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_sweep(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{1'b1, 8'(i), 1'b0});
      end
   endtask

   // One commit cycle; expect_enq queues the table write it must produce
   task automatic commit(input logic [63:0] pc, input logic tk, input logic mp,
                         input logic br, input logic expect_enq);
      commit_valid     = 1'b1;
      commit_is_branch = br;
      commit_pc        = pc;
      commit_taken     = tk;
      commit_mispred   = mp;
      if (expect_enq) begin
         exp_q.push_back('{1'b0, pc[9:2], tk});
      end
      tick();
      commit_valid     = 1'b0;
      commit_is_branch = 1'b0;
      commit_mispred   = 1'b0;
   endtask

   // Scoreboard monitor: a write happens when upd_valid and (sweep or en)
   always @(negedge clk) begin
      exp_t e;
      if (!reset && upd_valid && (upd_init || en)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_write: init=%0b idx=%0d taken=%0b, expected no write",
                     upd_init, upd_idx, upd_taken);
         end else begin
            e = exp_q.pop_front();
            if (upd_init !== e.init || upd_idx !== e.idx || upd_taken !== e.taken ||
                fetch_stall !== e.init) begin
               n_fails++;
               $display("FAIL table_write: got init=%0b idx=%0d taken=%0b stall=%0b, expected init=%0b idx=%0d taken=%0b stall=%0b",
                        upd_init, upd_idx, upd_taken, fetch_stall, e.init, e.idx, e.taken, e.init);
            end
         end
      end
   end

   logic [63:0] pcs [4];
   logic        tks [4];

   initial begin
      reset            = 1'b1;
      en               = 1'b0;
      clear_req        = 1'b0;
      commit_valid     = 1'b0;
      commit_is_branch = 1'b0;
      commit_pc        = '0;
      commit_taken     = 1'b0;
      commit_mispred   = 1'b0;

      // 1: reset then full sweep of 256 entries
      push_sweep(256);
      tick();
      reset = 1'b0;
      check("rst_stall", fetch_stall, 1);
      check("rst_init", upd_init, 1);
      check("rst_idx", upd_idx, 0);
      check("rst_ready", commit_ready, 0);
      repeat (128) tick();
      check("sweep_ready", commit_ready, 0);
      commit(64'h40, 1'b1, 1'b0, 1'b1, 1'b0);   // must be ignored while sweeping
      repeat (127) tick();
      en = 1'b1;
      check("run_stall", fetch_stall, 0);
      check("run_valid", upd_valid, 0);
      check("run_ready", commit_ready, 1);
      check("run_init", upd_init, 0);

      // 2: single taken branch, written the next cycle
      commit(64'h8000_0010, 1'b1, 1'b0, 1'b1, 1'b1);
      check("lat_valid", upd_valid, 1);
      check("lat_idx", upd_idx, 4);
      tick();
      check("lat_popped", upd_valid, 0);

      // 3: fill with en low, full boundary, in-order drain
      pcs = '{64'h1004, 64'h2008, 64'h300C, 64'h0FFC};
      tks = '{1'b1, 1'b0, 1'b1, 1'b0};
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("fill_ready", commit_ready, 1);
         commit(pcs[i], tks[i], 1'b0, 1'b1, 1'b1);
      end
      check("full_ready", commit_ready, 0);
      commit(64'h5000, 1'b1, 1'b0, 1'b1, 1'b0); // dropped: queue full
      check("hold_valid", upd_valid, 1);
      check("hold_idx", upd_idx, 1);
      en = 1'b1;
      check("full_pop_ready", commit_ready, 0);
      tick();
      check("ready_after_pop", commit_ready, 1);
      repeat (3) tick();
      check("drained", upd_valid, 0);

      // 3b: back-to-back enqueue while draining keeps order
      commit(64'h10, 1'b0, 1'b0, 1'b1, 1'b1);
      commit(64'h14, 1'b1, 1'b0, 1'b1, 1'b1);
      commit(64'h18, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("stream_drained", upd_valid, 0);

      // 4: clear_req flushes queued entries and drops same-cycle enqueue
      en = 1'b0;
      commit(64'h20, 1'b1, 1'b0, 1'b1, 1'b0);
      commit(64'h24, 1'b0, 1'b0, 1'b1, 1'b0);
      commit(64'h28, 1'b1, 1'b0, 1'b1, 1'b0);
      clear_req = 1'b1;
      push_sweep(256);
      commit(64'h2C, 1'b1, 1'b0, 1'b1, 1'b0);
      clear_req = 1'b0;
      check("clr_init", upd_init, 1);
      check("clr_idx", upd_idx, 0);
      check("clr_stall", fetch_stall, 1);
      repeat (256) tick();
      en = 1'b1;
      repeat (4) tick();
      check("clr_flushed", upd_valid, 0);

      // 5: reset at sweep index 100 restarts a full sweep
      reset = 1'b1;
      tick();
      reset = 1'b0;
      push_sweep(100);
      repeat (100) tick();
      check("mid_idx", upd_idx, 100);
      reset = 1'b1;
      push_sweep(256);
      tick();
      reset = 1'b0;
      check("restart_idx", upd_idx, 0);
      repeat (256) tick();
      check("restart_run", fetch_stall, 0);

      // 6: 10 branches (3 mispredicted) interleaved with 5 non-branch commits
      for (int i = 0; i < 15; i++) begin
         if (i % 3 == 2) begin
            check("nonbr_ready", commit_ready, 1);
            commit(64'h100 + 64'(4 * i), 1'b1, 1'b1, 1'b0, 1'b0);
         end else begin
            commit(64'h100 + 64'(4 * i), 1'(i & 1), (i % 6 == 0), 1'b1, 1'b1);
         end
      end
      repeat (2) tick();
`ifdef BP_UPD_STATS_EN
      check("stat_branches", stat_branches, 10);
      check("stat_mispreds", stat_mispreds, 3);
`endif
      clear_req = 1'b1;
      push_sweep(256);
      tick();
      clear_req = 1'b0;
`ifdef BP_UPD_STATS_EN
      check("stat_br_clr", stat_branches, 0);
      check("stat_mp_clr", stat_mispreds, 0);
`endif
      repeat (256) tick();
      repeat (3) tick();
      check("queue_empty", 64'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
